// File: rtl/seq_shifter8.sv
// seq_shifter8: one-bit-per-clock left/right logical/arithmetic shifter with start/done handshake.
module seq_shifter8 #(
    parameter int WIDTH = 8,
    parameter int SHW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] sr, sh;
    logic [SHW-1:0]   cnt;
    logic             lr_q, al_q;
    assign ready = state == IDLE;
    assign busy  = !ready;
    assign done  = state == DONE;
    always_comb sh = lr_q ? {sr[WIDTH-2:0], 1'b0} : {al_q & sr[WIDTH-1], sr[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            lr_q  <= 1'b0;
            al_q  <= 1'b0;
            dout  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sr   <= din;
                    cnt  <= shamt;
                    lr_q <= LR;
                    al_q <= AL;
                    if (shamt == '0) begin
                        state <= DONE;
                        dout  <= din;
                    end else state <= SHIFT;
                end
                SHIFT: begin
                    sr  <= sh;
                    cnt <= cnt - 1'b1;
                    // dout takes the post-shift value on the edge that enters DONE
                    if (cnt == SHW'(1)) begin
                        state <= DONE;
                        dout  <= sh;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shifter8.sv
// tb_seq_shifter8: table, corner-case sequences and random sweep against an arithmetic shift model.
module tb_seq_shifter8;
    logic       clk = 1'b0;
    logic       rst, start, LR, AL, ready, busy, done;
    logic [7:0] din, dout, last;
    logic [2:0] shamt;
    int checks = 0, failures = 0;
    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic       lr, al;
        logic [7:0] e;
    } vec_t;
    vec_t tbl[9];
    always #5 clk = ~clk;
    seq_shifter8 dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .shamt(shamt),
        .LR(LR), .AL(AL), .ready(ready), .busy(busy), .done(done), .dout(dout)
    );
    // shifts expressed as multiplication / floor division by powers of two
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic lr, input logic al);
        int p, v;
        p = 1 << s;
        if (lr) return 8'((int'(d) * p) % 256);
        v = (al && d[7]) ? int'(d) - 256 : int'(d);
        if (v < 0) return 8'((v - (p - 1)) / p);
        return 8'(v / p);
    endfunction
    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic lr, input logic al, input logic [7:0] e);
        chk("ready_before", ready, 1);
        din = d; shamt = s; LR = lr; AL = al; start = 1;
        tick;
        start = 0;
        din = 8'($urandom); shamt = 3'($urandom); LR = 1'($urandom); AL = 1'($urandom);
        for (int k = 1; k <= int'(s) + 1; k++) begin
            chk("busy", busy, 1);
            chk("done", done, 8'(k == int'(s) + 1));
            if (k <= int'(s)) chk("dout_hold", dout, last);
            else chk("dout", dout, e);
            tick;
        end
        chk("ready_after", ready, 1);
        chk("done_after", done, 0);
        last = e;
    endtask
    initial begin
        int np;
        tbl[0] = '{8'hB5, 3'd3, 1'b1, 1'b0, 8'hA8};
        tbl[1] = '{8'hB5, 3'd2, 1'b0, 1'b1, 8'hED};
        tbl[2] = '{8'hB5, 3'd2, 1'b0, 1'b0, 8'h2D};
        tbl[3] = '{8'h80, 3'd0, 1'b0, 1'b1, 8'h80};
        tbl[4] = '{8'h80, 3'd7, 1'b0, 1'b1, 8'hFF};
        tbl[5] = '{8'hFF, 3'd7, 1'b1, 1'b1, 8'h80};
        tbl[6] = '{8'h81, 3'd7, 1'b0, 1'b0, 8'h01};
        tbl[7] = '{8'h7E, 3'd1, 1'b0, 1'b1, 8'h3F};
        tbl[8] = '{8'h3C, 3'd0, 1'b1, 1'b0, 8'h3C};
        rst = 1; start = 0; din = 0; shamt = 0; LR = 0; AL = 0; last = 0;
        tick;
        tick;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_ready", ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_dout", dout, 8'h00);
        end
        for (int i = 0; i < 9; i++) run_op(tbl[i].d, tbl[i].s, tbl[i].lr, tbl[i].al, tbl[i].e);
        din = 8'h0F; shamt = 3'd4; LR = 1; AL = 0; start = 1;
        tick;
        start = 0;
        tick;
        din = 8'hFF; shamt = 3'd1; start = 1;
        tick;
        start = 0;
        np = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                np++;
                chk("ignore_dout", dout, 8'hF0);
            end
            tick;
        end
        chk("ignore_pulses", 8'(np), 8'd1);
        chk("ignore_ready", ready, 1);
        last = 8'hF0;
        din = 8'h55; shamt = 3'd5; LR = 1; AL = 0; start = 1;
        tick;
        start = 0;
        tick;
        tick;
        chk("abort_busy_pre", busy, 1);
        rst = 1;
        tick;
        rst = 0;
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_dout", dout, 8'h00);
        np = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) np++;
            tick;
        end
        chk("abort_pulses", 8'(np), 8'd0);
        last = 0;
        rst = 1; start = 1; din = 8'hAA; shamt = 3'd0;
        tick;
        rst = 0; start = 0;
        chk("rst_start_ready", ready, 1);
        tick;
        chk("rst_start_done", done, 0);
        chk("rst_start_dout", dout, 8'h00);
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] d;
            logic [2:0] s;
            logic lr, al;
            d = 8'($urandom); s = 3'($urandom); lr = 1'($urandom); al = 1'($urandom);
            run_op(d, s, lr, al, ref_shift(d, int'(s), lr, al));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_shifter8.md
Name: seq_shifter8

Overview:
- Multi-cycle sequential counterpart of the combinational 8-bit barrel shifter: performs the same left/right, logical/arithmetic shift, one bit position per clock, under a start/done handshake.
- Used where area matters more than latency, and as a cycle-accurate reference the combinational shifter is checked against on the lab board.
- Shift semantics are identical to the barrel shifter for every din/shamt/LR/AL combination.

Parameters:
- WIDTH, 8, data width; all tests at 8.
- SHW, 3, shift-amount width; log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when ready=1
- din  input  WIDTH  operand, latched with start
- shamt  input  SHW  shift amount 0..WIDTH-1, latched with start
- LR  input  1  1 = shift left, 0 = shift right; latched with start
- AL  input  1  right shifts only: 1 = arithmetic (fill with din MSB), 0 = logical (fill 0); ignored on left shifts; latched with start
- ready  output  1  high in IDLE; a start is accepted only when ready=1
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; dout is valid from this cycle onward
- dout  output  WIDTH  result register; holds its value until the next completion

Behaviour:
- States: IDLE, SHIFT, DONE. Each output is a register, or decodes from the state register only.
- Reset (rst=1 at a clock edge): state = IDLE, ready=1, busy=0, done=0, dout=0, internal shift register = 0, count = 0. Reset aborts any operation in progress; no done pulse follows.
- IDLE:
  - start=1 at edge E0: latch din into the shift register, and latch shamt into count, plus LR and AL.
  - If shamt != 0, go to SHIFT. If shamt = 0, go to DONE.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - LR=1: shift register moves left by one, LSB filled with 0.
  - LR=0, AL=0: moves right by one, MSB filled with 0.
  - LR=0, AL=1: moves right by one, MSB refilled with the current MSB (sign replication).
  - count decrements. The state moves to DONE on the edge where count goes 1 -> 0.
- Entering DONE: dout is loaded with the final shift-register value on the same edge. done=1 for exactly one cycle, then the state returns to IDLE unconditionally.
- Latency: done is high in the cycle after edge E0+shamt, so the operation occupies shamt+1 edges. The next start can be accepted at the edge that leaves DONE + 1, i.e. once ready=1 again.
- start while busy=1 is ignored and not queued. Changes to din/shamt/LR/AL after E0 have no effect on the operation in flight.
- ready = (state==IDLE); busy = !ready.
- dout keeps its last result through IDLE and through the next operation until that operation's DONE.
- No wrap or rotation: bits shifted out are discarded. shamt = WIDTH-1 is the maximum.
- Simultaneous rst and start: rst wins and start is dropped.

Test Plan:
- Reset, then idle 3 cycles -> ready=1, busy=0, done=0, dout=8'h00 throughout.
- din=8'hB5, shamt=3, LR=1, AL=x, start 1 cycle -> busy for 4 cycles, done pulses in the 4th cycle after the start edge, dout=8'hA8.
- din=8'hB5, shamt=2, LR=0, AL=1 -> dout=8'hED at done (cycle 3). Repeat with AL=0 -> dout=8'h2D.
- din=8'h80, shamt=0, LR=0, AL=1 -> done in the cycle right after the start edge, dout=8'h80. Then shamt=7, LR=0, AL=1 -> dout=8'hFF at done (cycle 8).
- Start with din=8'h0F, shamt=4, LR=1. While busy, pulse start with din=8'hFF, shamt=1 -> the second request is ignored, a single done pulse, dout=8'hF0.
- Start with din=8'h55, shamt=5. Assert rst in the 3rd busy cycle -> next cycle ready=1, dout=8'h00, no done pulse. A following start still works correctly, matching the combinational shifter over a random sweep of 1000 vectors.
